// File: rtl/icache_data_array.sv
// Multi-way I-cache data store with a wrapping line-refill buffer.
// The buffer forwards words that have already arrived and commits the whole line in one write.
module icache_data_array #(
    parameter int WAYS       = 2,
    parameter int INDEX_W    = 7,
    parameter int LINE_WORDS = 8,
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int SETS      = 2 ** INDEX_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               rd_en,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [OFF_W-1:0]   rd_offset,
    input  logic [WAYS-1:0]    rd_hit_way,
    output logic               rd_valid,
    output logic [31:0]        rd_data,
    output logic               rd_fwd,
    output logic               rd_stall,
    input  logic               rf_start,
    input  logic [INDEX_W-1:0] rf_index,
    input  logic [WAY_W-1:0]   rf_way,
    input  logic [OFF_W-1:0]   rf_offset,
    input  logic               rf_beat_valid,
    input  logic [31:0]        rf_beat_data,
    output logic               rf_busy,
    output logic               rf_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_COMMIT,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [INDEX_W-1:0]        idx_q, idx_d;
    logic [WAY_W-1:0]          way_q, way_d;
    logic [OFF_W-1:0]          ptr_q, ptr_d;
    logic [OFF_W-1:0]          cnt_q, cnt_d;
    logic [LINE_WORDS-1:0]     mask_q, mask_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      fwd_q, fwd_d;
    logic [31:0]               fwd_word_q, fwd_word_d;
    logic [LINE_WORDS-1:0][31:0] lbuf_q;
    logic [WAYS-1:0][31:0]     way_word;
    logic                      beat_we;
    logic                      rd_acc;
    logic                      fwd_hit;
    logic [31:0]               sel_word;

    assign rd_stall = (state_q == S_COMMIT);
    assign rf_busy  = (state_q == S_FILL) || (state_q == S_COMMIT);
    assign rf_done  = (state_q == S_DONE);
    assign rd_valid = rd_valid_q;
    assign rd_fwd   = fwd_q;
    assign rd_acc   = rd_en & ~rd_stall;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        way_d   = way_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        beat_we = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rf_start) begin
                    idx_d   = rf_index;
                    way_d   = rf_way;
                    ptr_d   = rf_offset;
                    cnt_d   = '0;
                    mask_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (rf_beat_valid) begin
                    beat_we       = 1'b1;
                    mask_d[ptr_q] = 1'b1;
                    ptr_d         = ptr_q + 1'b1;
                    cnt_d         = cnt_q + 1'b1;
                    // Counter wraps to zero on the last beat of the line
                    if (cnt_q == '1) state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_DONE;
            S_DONE: begin
                mask_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Mask already includes a beat landing this cycle, so that beat is forwarded too
    always_comb begin
        fwd_hit    = (state_q == S_FILL) && (rd_index == idx_q)
                     && mask_d[rd_offset];
        rd_valid_d = rd_acc;
        fwd_d      = rd_acc & fwd_hit;
        fwd_word_d = fwd_word_q;
        if (rd_acc) begin
            fwd_word_d = (beat_we && (ptr_q == rd_offset))
                         ? rf_beat_data : lbuf_q[rd_offset];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            way_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            rd_valid_q <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_word_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            way_q      <= way_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            rd_valid_q <= rd_valid_d;
            fwd_q      <= fwd_d;
            fwd_word_q <= fwd_word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_we) lbuf_q[ptr_q] <= rf_beat_data;
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [LINE_WORDS-1:0][31:0] mem_q [SETS];
        logic [31:0]                 rdw_q;
        logic                        we;

        assign we = (state_q == S_COMMIT) && (way_q == WAY_W'(w));

        always_ff @(posedge clk) begin
            if (we) mem_q[idx_q] <= lbuf_q;
            if (rd_acc) rdw_q <= mem_q[rd_index][rd_offset];
        end

        assign way_word[w] = rdw_q;
    end

    always_comb begin
        sel_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (rd_hit_way[w]) sel_word = sel_word | way_word[w];
        end
        rd_data = '0;
        if (rd_valid_q) rd_data = fwd_q ? fwd_word_q : sel_word;
    end

    always_ff @(posedge clk) begin
        if (resetn && rd_valid_q) assert ($onehot0(rd_hit_way));
    end

endmodule

// File: tb/tb_icache_data_array.sv
// Directed bench for icache_data_array: preload, wrapping refill,
// forwarding, commit stall, reset mid-refill and zero-hit reads.
module tb_icache_data_array;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rd_en;
    logic [6:0]  rd_index;
    logic [2:0]  rd_offset;
    logic [1:0]  rd_hit_way;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_fwd;
    logic        rd_stall;
    logic        rf_start;
    logic [6:0]  rf_index;
    logic [0:0]  rf_way;
    logic [2:0]  rf_offset;
    logic        rf_beat_valid;
    logic [31:0] rf_beat_data;
    logic        rf_busy;
    logic        rf_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    icache_data_array dut (
        .clk          (clk),
        .resetn       (resetn),
        .rd_en        (rd_en),
        .rd_index     (rd_index),
        .rd_offset    (rd_offset),
        .rd_hit_way   (rd_hit_way),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_fwd       (rd_fwd),
        .rd_stall     (rd_stall),
        .rf_start     (rf_start),
        .rf_index     (rf_index),
        .rf_way       (rf_way),
        .rf_offset    (rf_offset),
        .rf_beat_valid(rf_beat_valid),
        .rf_beat_data (rf_beat_data),
        .rf_busy      (rf_busy),
        .rf_done      (rf_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_issue(input logic [6:0] i, input logic [2:0] o);
        rd_en     = 1'b1;
        rd_index  = i;
        rd_offset = o;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] hit,
                            input logic v, input logic [31:0] d,
                            input logic f);
        rd_hit_way = hit;
        #1;
        check({tag, "_valid"}, 32'(rd_valid), 32'(v));
        check({tag, "_data"}, rd_data, d);
        check({tag, "_fwd"}, 32'(rd_fwd), 32'(f));
    endtask

    task automatic refill(input logic [6:0] idx, input logic way,
                          input logic [2:0] off, input logic [31:0] base);
        rf_start  = 1'b1;
        rf_index  = idx;
        rf_way    = way;
        rf_offset = off;
        tick();
        rf_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rf_beat_valid = 1'b1;
            rf_beat_data  = base + 32'(i);
            tick();
        end
        rf_beat_valid = 1'b0;
        check("pre_commit_stall", 32'(rd_stall), 32'd1);
        tick();
        check("pre_done", 32'(rf_done), 32'd1);
        tick();
    endtask

    initial begin
        resetn        = 1'b0;
        rd_en         = 1'b0;
        rd_index      = '0;
        rd_offset     = '0;
        rd_hit_way    = '0;
        rf_start      = 1'b0;
        rf_index      = '0;
        rf_way        = '0;
        rf_offset     = '0;
        rf_beat_valid = 1'b0;
        rf_beat_data  = '0;
        repeat (3) tick();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_fwd", 32'(rd_fwd), 32'd0);
        check("rst_busy", 32'(rf_busy), 32'd0);
        check("rst_done", 32'(rf_done), 32'd0);
        check("rst_stall", 32'(rd_stall), 32'd0);
        resetn = 1'b1;
        tick();

        // Preload set5 both ways and set9 way0
        refill(7'd5, 1'b1, 3'd0, 32'hA5A5_0000);
        refill(7'd5, 1'b0, 3'd0, 32'h5A5A_0000);
        refill(7'd9, 1'b0, 3'd0, 32'h9000_0000);

        rd_issue(7'd5, 3'd3);
        tick();
        rd_en = 1'b0;
        rd_check("t1_way1", 2'b10, 1'b1, 32'hA5A5_0003, 1'b0);
        rd_issue(7'd5, 3'd3);
        tick();
        rd_en = 1'b0;
        rd_check("t1_way0", 2'b01, 1'b1, 32'h5A5A_0003, 1'b0);
        rd_issue(7'd5, 3'd3);
        tick();
        rd_en = 1'b0;
        rd_check("t6_nohit", 2'b00, 1'b1, 32'h0, 1'b0);
        tick();
        check("idle_valid", 32'(rd_valid), 32'd0);

        // Wrapping refill of set9 way0 starting at word 6
        rf_start  = 1'b1;
        rf_index  = 7'd9;
        rf_way    = 1'b0;
        rf_offset = 3'd6;
        tick();
        rf_start = 1'b0;
        check("fill_busy", 32'(rf_busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            rf_beat_valid = 1'b1;
            rf_beat_data  = 32'h60 + 32'(i);
            tick();
        end
        rf_beat_valid = 1'b0;
        rd_issue(7'd9, 3'd7);
        tick();
        rd_issue(7'd9, 3'd2);
        rd_check("t3_fwd_off7", 2'b01, 1'b1, 32'h61, 1'b1);
        tick();
        rd_en = 1'b0;
        rd_check("t3_off2_array", 2'b01, 1'b1, 32'h9000_0002, 1'b0);

        rf_beat_valid = 1'b1;
        rf_beat_data  = 32'h63;
        rd_issue(7'd9, 3'd1);
        tick();
        rf_beat_valid = 1'b0;
        rd_en = 1'b0;
        rd_check("fwd_same_beat", 2'b10, 1'b1, 32'h63, 1'b1);

        rd_issue(7'd5, 3'd3);
        rf_start  = 1'b1;
        rf_index  = 7'd5;
        rf_way    = 1'b1;
        rf_offset = 3'd0;
        check("other_idx_stall", 32'(rd_stall), 32'd0);
        tick();
        rf_start = 1'b0;
        rd_en    = 1'b0;
        rd_check("other_idx", 2'b10, 1'b1, 32'hA5A5_0003, 1'b0);
        check("busy_after_start", 32'(rf_busy), 32'd1);

        for (int i = 4; i < 8; i++) begin
            rf_beat_valid = 1'b1;
            rf_beat_data  = 32'h60 + 32'(i);
            tick();
        end
        rf_beat_valid = 1'b0;
        rd_issue(7'd9, 3'd0);
        check("t4_commit_stall", 32'(rd_stall), 32'd1);
        check("t4_commit_busy", 32'(rf_busy), 32'd1);
        check("t4_commit_done", 32'(rf_done), 32'd0);
        tick();
        rd_hit_way = 2'b01;
        #1;
        check("t4_stalled_valid", 32'(rd_valid), 32'd0);
        check("t4_stalled_data", rd_data, 32'd0);
        check("t2_done", 32'(rf_done), 32'd1);
        check("t2_done_busy", 32'(rf_busy), 32'd0);
        tick();
        rd_en = 1'b0;
        rd_check("t4_reissue", 2'b01, 1'b1, 32'h62, 1'b0);
        check("done_pulse_end", 32'(rf_done), 32'd0);
        rd_issue(7'd9, 3'd6);
        tick();
        rd_en = 1'b0;
        rd_check("t2_word6", 2'b01, 1'b1, 32'h60, 1'b0);
        rd_issue(7'd9, 3'd5);
        tick();
        rd_en = 1'b0;
        rd_check("t2_word5", 2'b01, 1'b1, 32'h67, 1'b0);
        rd_issue(7'd5, 3'd0);
        tick();
        rd_en = 1'b0;
        rd_check("t6_way1_kept", 2'b10, 1'b1, 32'hA5A5_0000, 1'b0);

        // Reset in the middle of a refill
        rf_start  = 1'b1;
        rf_index  = 7'd9;
        rf_way    = 1'b0;
        rf_offset = 3'd0;
        tick();
        rf_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rf_beat_valid = 1'b1;
            rf_beat_data  = 32'h70 + 32'(i);
            tick();
        end
        rf_beat_valid = 1'b0;
        check("t5_busy_pre", 32'(rf_busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("t5_busy_rst", 32'(rf_busy), 32'd0);
        check("t5_valid_rst", 32'(rd_valid), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        rd_issue(7'd9, 3'd1);
        tick();
        rd_en = 1'b0;
        rd_check("t5_old_off1", 2'b01, 1'b1, 32'h63, 1'b0);
        rd_issue(7'd9, 3'd0);
        tick();
        rd_en = 1'b0;
        rd_check("t5_old_off0", 2'b01, 1'b1, 32'h62, 1'b0);
        check("t5_busy_after", 32'(rf_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
